// File: rtl/memory_controller_burst_param_if.sv
// Host burst bus plus byte-serial PSRAM controller bus for memory_controller_burst_param.
// The controller is the slave side; the host/PSRAM environment is the master side.
interface memory_controller_burst_param_if #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 22,
   parameter int MAX_BURST = 8
);
   localparam int LEN_W = $clog2(MAX_BURST + 1);
   localparam int MA_W  = ADDR_W + $clog2(DATA_W / 8);

   // Handshakes: rd/we are one-cycle strobes honoured only while ready is high;
   // a write word transfers on a cycle where wr_valid and wr_ready are both high;
   // rd_valid is a one-cycle pulse with no back-pressure; PSRAM bytes move on the
   // rising edges of m_ready_for_next_byte / m_byte_available, never on levels.
   logic [ADDR_W-1:0] a;
   logic [LEN_W-1:0]  burst_len;
   logic              rd;
   logic              we;
   logic              ready;
   logic              err;
   logic [DATA_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_last;
   logic [MA_W-1:0]   m_a;
   logic              m_rd;
   logic              m_we;
   logic              m_rend;
   logic              m_wend;
   logic [7:0]        m_din;
   logic [7:0]        m_dout;
   logic              m_byte_available;
   logic              m_ready_for_next_byte;
   logic              m_ready;

   modport slave (
      input  a, burst_len, rd, we, wr_data, wr_valid,
      input  m_dout, m_byte_available, m_ready_for_next_byte, m_ready,
      output ready, err, wr_ready, rd_data, rd_valid, rd_last,
      output m_a, m_rd, m_we, m_rend, m_wend, m_din
   );

   modport master (
      output a, burst_len, rd, we, wr_data, wr_valid,
      output m_dout, m_byte_available, m_ready_for_next_byte, m_ready,
      input  ready, err, wr_ready, rd_data, rd_valid, rd_last,
      input  m_a, m_rd, m_we, m_rend, m_wend, m_din
   );
endinterface

// File: rtl/memory_controller_burst_param.sv
// Burst adapter: buffers host words and serialises them MSB-first onto a byte-wide
// PSRAM controller, and reassembles read bytes back into host words.
module memory_controller_burst_param #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 22,
   parameter int MAX_BURST  = 8,
   parameter int PAGE_BYTES = 1024
) (
   input  logic                            clk,
   input  logic                            rst_n,
   memory_controller_burst_param_if.slave  bus,
   output logic [2:0]                      o_dbg_state
);
   localparam int BW      = DATA_W / 8;
   localparam int BYTE_AW = $clog2(BW);
   localparam int MA_W    = ADDR_W + BYTE_AW;
   localparam int LEN_W   = $clog2(MAX_BURST + 1);
   localparam int IDX_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int BI_W    = $clog2(BW + 1);
   localparam int CNT_W   = $clog2(MAX_BURST * BW + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_FILL, S_WR_ISSUE, S_WR_XFER, S_RD_ISSUE, S_RD_XFER, S_DONE
   } state_t;

   state_t            r_state, w_next;
   logic [DATA_W-1:0] r_buf [MAX_BURST];
   logic [LEN_W-1:0]  r_len;
   logic [MA_W-1:0]   r_m_a;
   logic [IDX_W-1:0]  r_word_idx;
   logic [BI_W-1:0]   r_byte_idx;
   logic [CNT_W-1:0]  r_byte_cnt;
   logic [DATA_W-1:0] r_asm, r_rd_data;
   logic              r_err, r_rd_valid, r_rd_last, r_wend, r_rend;
   logic              r_rfnb_d, r_ba_d;

   logic              w_cmd, w_bad, w_last_word, w_last_byte, w_word_end, w_rend_hit;
   logic              w_rfnb_rise, w_ba_rise, w_m_we, w_m_rd, w_wr_ready;
   logic [MA_W-1:0]   w_m_a_new;
   logic [31:0]       w_page_off;
   logic [CNT_W-1:0]  w_total;
   logic [DATA_W-1:0] w_asm_next, w_cur;
   logic [BI_W-1:0]   w_din_sel;
   logic [7:0]        w_din;

   assign w_cmd       = bus.we | bus.rd;
   assign w_m_a_new   = MA_W'(bus.a) << BYTE_AW;
   assign w_page_off  = 32'(w_m_a_new) & 32'(PAGE_BYTES - 1);
   assign w_bad       = (bus.burst_len == '0) ||
                        (32'(bus.burst_len) > 32'(MAX_BURST)) ||
                        ((w_page_off + 32'(bus.burst_len) * 32'(BW)) > 32'(PAGE_BYTES));
   assign w_total     = CNT_W'(r_len) * CNT_W'(BW);
   assign w_last_word = (LEN_W'(r_word_idx) == r_len - LEN_W'(1));
   assign w_word_end  = (r_byte_idx == BI_W'(BW - 1));
   assign w_last_byte = (r_byte_cnt == w_total - CNT_W'(1));
   // A single-byte burst has no penultimate byte, so its only byte raises m_rend.
   assign w_rend_hit  = (w_total == CNT_W'(1)) || (r_byte_cnt == w_total - CNT_W'(2));
   assign w_rfnb_rise = bus.m_ready_for_next_byte & ~r_rfnb_d;
   assign w_ba_rise   = bus.m_byte_available & ~r_ba_d;
   assign w_asm_next  = (r_asm << 8) | DATA_W'(bus.m_dout);

   always_comb begin
      w_next     = r_state;
      w_m_we     = 1'b0;
      w_m_rd     = 1'b0;
      w_wr_ready = 1'b0;
      case (r_state)
         S_IDLE:     if (w_cmd && !w_bad) w_next = bus.we ? S_WR_FILL : S_RD_ISSUE;
         S_WR_FILL: begin
            w_wr_ready = 1'b1;
            if (bus.wr_valid && w_last_word) w_next = S_WR_ISSUE;
         end
         S_WR_ISSUE: if (bus.m_ready) begin
            w_m_we = 1'b1;
            w_next = S_WR_XFER;
         end
         S_WR_XFER:  if (w_rfnb_rise && w_last_byte) w_next = S_DONE;
         S_RD_ISSUE: if (bus.m_ready) begin
            w_m_rd = 1'b1;
            w_next = S_RD_XFER;
         end
         S_RD_XFER:  if (w_ba_rise && w_last_byte) w_next = S_DONE;
         S_DONE:     w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_cur     = r_buf[r_word_idx];
      w_din_sel = BI_W'(BW - 1) - r_byte_idx;
      w_din     = 8'h00;
      if (r_state == S_WR_XFER) w_din = w_cur[w_din_sel*8 +: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // The word buffer carries no reset; its contents are meaningless outside a burst.
   always_ff @(posedge clk) begin
      if (r_state == S_WR_FILL && bus.wr_valid) r_buf[r_word_idx] <= bus.wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len      <= '0;
         r_m_a      <= '0;
         r_word_idx <= '0;
         r_byte_idx <= '0;
         r_byte_cnt <= '0;
         r_asm      <= '0;
         r_rd_data  <= '0;
         r_err      <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
         r_wend     <= 1'b0;
         r_rend     <= 1'b0;
         r_rfnb_d   <= 1'b0;
         r_ba_d     <= 1'b0;
      end else begin
         r_rfnb_d   <= bus.m_ready_for_next_byte;
         r_ba_d     <= bus.m_byte_available;
         r_err      <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
         case (r_state)
            S_IDLE: if (w_cmd) begin
               if (w_bad) begin
                  r_err <= 1'b1;
               end else begin
                  r_len      <= bus.burst_len;
                  r_m_a      <= w_m_a_new;
                  r_wend     <= 1'b0;
                  r_rend     <= 1'b0;
                  r_word_idx <= '0;
                  r_byte_idx <= '0;
                  r_byte_cnt <= '0;
               end
            end
            S_WR_FILL: if (bus.wr_valid) begin
               r_word_idx <= w_last_word ? '0 : r_word_idx + IDX_W'(1);
            end
            S_WR_XFER: if (w_rfnb_rise) begin
               r_byte_cnt <= r_byte_cnt + CNT_W'(1);
               r_byte_idx <= w_word_end ? '0 : r_byte_idx + BI_W'(1);
               if (w_word_end) r_word_idx <= r_word_idx + IDX_W'(1);
               if (w_last_byte) r_wend <= 1'b1;
            end
            S_RD_XFER: if (w_ba_rise) begin
               r_asm      <= w_asm_next;
               r_byte_cnt <= r_byte_cnt + CNT_W'(1);
               r_byte_idx <= w_word_end ? '0 : r_byte_idx + BI_W'(1);
               if (w_word_end) begin
                  r_word_idx <= r_word_idx + IDX_W'(1);
                  r_rd_data  <= w_asm_next;
                  r_rd_valid <= 1'b1;
                  r_rd_last  <= w_last_word;
               end
               if (w_rend_hit) r_rend <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.ready    = rst_n && (r_state == S_IDLE) && bus.m_ready && !bus.rd && !bus.we;
   assign bus.err      = r_err;
   assign bus.wr_ready = w_wr_ready;
   assign bus.rd_data  = r_rd_data;
   assign bus.rd_valid = r_rd_valid;
   assign bus.rd_last  = r_rd_last;
   assign bus.m_a      = r_m_a;
   assign bus.m_rd     = w_m_rd;
   assign bus.m_we     = w_m_we;
   assign bus.m_rend   = r_rend;
   assign bus.m_wend   = r_wend;
   assign bus.m_din    = w_din;
   assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_memory_controller_burst_param.sv
// Directed bench: a 32-bit/8-word controller for the main cases and a 64-bit/4-word
// controller for long writes with gaps and a held-high byte strobe.
module tb_memory_controller_burst_param;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] st1, st2;
   int         checks = 0;
   int         failures = 0;
   logic       snap_valid, snap_last, snap_rend;
   logic [31:0] snap_data;
   logic [7:0]  wb [4];
   logic [63:0] wd;

   always #5 clk = ~clk;

   memory_controller_burst_param_if #(.DATA_W(32), .ADDR_W(22), .MAX_BURST(8)) b1 ();
   memory_controller_burst_param_if #(.DATA_W(64), .ADDR_W(22), .MAX_BURST(4)) b2 ();

   memory_controller_burst_param #(.DATA_W(32), .ADDR_W(22), .MAX_BURST(8), .PAGE_BYTES(1024))
      u1 (.clk(clk), .rst_n(rst_n), .bus(b1), .o_dbg_state(st1));
   memory_controller_burst_param #(.DATA_W(64), .ADDR_W(22), .MAX_BURST(4), .PAGE_BYTES(1024))
      u2 (.clk(clk), .rst_n(rst_n), .bus(b2), .o_dbg_state(st2));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // All driver tasks start and end just after a falling edge.
   task automatic cmd1(input logic w, input logic r, input logic [21:0] addr, input logic [3:0] len);
      b1.we = w; b1.rd = r; b1.a = addr; b1.burst_len = len;
      @(negedge clk);
      b1.we = 1'b0; b1.rd = 1'b0;
   endtask

   task automatic rfnb1();
      b1.m_ready_for_next_byte = 1'b1;
      @(negedge clk);
      b1.m_ready_for_next_byte = 1'b0;
      @(negedge clk);
   endtask

   task automatic ba1(input logic [7:0] d);
      b1.m_dout = d; b1.m_byte_available = 1'b1;
      @(negedge clk);
      snap_valid = b1.rd_valid; snap_last = b1.rd_last;
      snap_data = b1.rd_data; snap_rend = b1.m_rend;
      b1.m_byte_available = 1'b0;
      @(negedge clk);
   endtask

   task automatic write_word1(input logic [31:0] d);
      b1.wr_data = d; b1.wr_valid = 1'b1;
      @(negedge clk);
      b1.wr_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      b1.a = '0; b1.burst_len = '0; b1.rd = 0; b1.we = 0; b1.wr_data = '0; b1.wr_valid = 0;
      b1.m_dout = '0; b1.m_byte_available = 0; b1.m_ready_for_next_byte = 0; b1.m_ready = 1;
      b2.a = '0; b2.burst_len = '0; b2.rd = 0; b2.we = 0; b2.wr_data = '0; b2.wr_valid = 0;
      b2.m_dout = '0; b2.m_byte_available = 0; b2.m_ready_for_next_byte = 0; b2.m_ready = 1;
      @(negedge clk); @(negedge clk);
      check("rst_state", st1, 0);
      check("rst_ready", b1.ready, 0);
      check("rst_err", b1.err, 0);
      check("rst_m_a", b1.m_a, 0);
      check("rst_wr_ready", b1.wr_ready, 0);
      check("rst_m_we", b1.m_we, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_ready", b1.ready, 1);

      // single-word write at a=0x10
      b1.a = 22'h10; b1.burst_len = 4'd1; b1.we = 1'b1;
      #1 check("ready_low_on_strobe", b1.ready, 0);
      @(negedge clk);
      b1.we = 1'b0;
      check("wr_m_a", b1.m_a, 24'h40);
      check("wr_fill_state", st1, 1);
      check("wr_ready", b1.wr_ready, 1);
      write_word1(32'hA1B2C3D4);
      check("wr_issue_state", st1, 2);
      check("m_we_pulse", b1.m_we, 1);
      @(negedge clk);
      check("wr_xfer_state", st1, 3);
      check("m_we_one_cycle", b1.m_we, 0);
      wb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      for (int i = 0; i < 4; i++) begin
         check("wr_m_din", b1.m_din, wb[i]);
         check("wr_wend_early", b1.m_wend, 0);
         rfnb1();
      end
      check("wr_wend", b1.m_wend, 1);
      check("wr_back_idle", st1, 0);
      check("wr_ready_back", b1.ready, 1);

      // two-word read at a=0
      cmd1(1'b0, 1'b1, 22'h0, 4'd2);
      check("rd_issue_state", st1, 4);
      check("m_rd_pulse", b1.m_rd, 1);
      check("wend_cleared", b1.m_wend, 0);
      @(negedge clk);
      check("rd_xfer_state", st1, 5);
      for (int i = 0; i < 8; i++) begin
         ba1(8'h11 + 8'(i));
         check("rd_valid", snap_valid, (i == 3 || i == 7));
         check("rd_rend", snap_rend, (i >= 6));
         if (i == 3) begin
            check("rd_word0", snap_data, 32'h11121314);
            check("rd_last0", snap_last, 0);
         end
         if (i == 7) begin
            check("rd_word1", snap_data, 32'h15161718);
            check("rd_last1", snap_last, 1);
         end
      end
      check("rd_valid_after", b1.rd_valid, 0);
      check("rd_back_idle", st1, 0);
      check("rend_held", b1.m_rend, 1);

      // page-crossing reject, oversize reject, exact page-end accept
      cmd1(1'b1, 1'b0, 22'hFF, 4'd2);
      check("cross_err", b1.err, 1);
      check("cross_idle", st1, 0);
      check("cross_no_we", b1.m_we, 0);
      check("cross_no_rd", b1.m_rd, 0);
      @(negedge clk);
      check("err_one_cycle", b1.err, 0);
      cmd1(1'b0, 1'b1, 22'h0, 4'd9);
      check("len9_err", b1.err, 1);
      check("len9_idle", st1, 0);
      cmd1(1'b0, 1'b1, 22'hFE, 4'd2);
      check("edge_accept_state", st1, 4);
      check("edge_accept_no_err", b1.err, 0);
      check("edge_m_a", b1.m_a, 24'h3F8);
      @(negedge clk);
      for (int i = 0; i < 8; i++) ba1(8'h00);
      check("edge_done_idle", st1, 0);

      // rd and we together take the write path; zero length rejected
      cmd1(1'b1, 1'b1, 22'h20, 4'd1);
      check("both_write_state", st1, 1);
      check("both_m_a", b1.m_a, 24'h80);
      write_word1(32'h01020304);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check("both_m_din", b1.m_din, 8'(i + 1));
         rfnb1();
      end
      check("both_wend", b1.m_wend, 1);
      cmd1(1'b1, 1'b0, 22'h5, 4'd0);
      check("len0_err", b1.err, 1);
      check("len0_idle", st1, 0);

      // reset in the middle of a read, then a clean read
      cmd1(1'b0, 1'b1, 22'h4, 4'd1);
      @(negedge clk);
      ba1(8'h55); ba1(8'h66); ba1(8'h77);
      rst_n = 1'b0;
      #1;
      check("mid_rst_state", st1, 0);
      check("mid_rst_m_a", b1.m_a, 0);
      check("mid_rst_rd_data", b1.rd_data, 0);
      check("mid_rst_rend", b1.m_rend, 0);
      check("mid_rst_ready", b1.ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cmd1(1'b0, 1'b1, 22'h8, 4'd1);
      check("post_rst_m_a", b1.m_a, 24'h20);
      @(negedge clk);
      ba1(8'hDE); ba1(8'hAD);
      check("post_rst_rend_early", snap_rend, 0);
      ba1(8'hBE);
      check("post_rst_rend", snap_rend, 1);
      ba1(8'hEF);
      check("post_rst_valid", snap_valid, 1);
      check("post_rst_data", snap_data, 32'hDEADBEEF);
      check("post_rst_last", snap_last, 1);

      // 64-bit controller: four words with gaps, held-high byte strobe
      b2.a = 22'h3; b2.burst_len = 3'd4; b2.we = 1'b1;
      @(negedge clk);
      b2.we = 1'b0;
      check("w64_state", st2, 1);
      check("w64_m_a", b2.m_a, 25'h18);
      for (int w = 0; w < 4; w++) begin
         b2.wr_valid = 1'b0;
         @(negedge clk);
         check("w64_gap_wr_ready", b2.wr_ready, 1);
         for (int b = 0; b < 8; b++) wd = {wd[55:0], 8'(w * 8 + b)};
         b2.wr_data = wd; b2.wr_valid = 1'b1;
         @(negedge clk);
      end
      b2.wr_valid = 1'b0;
      check("w64_issue", st2, 2);
      check("w64_m_we", b2.m_we, 1);
      @(negedge clk);
      check("w64_xfer", st2, 3);
      check("w64_byte0", b2.m_din, 8'h00);
      b2.m_ready_for_next_byte = 1'b1;
      @(negedge clk); @(negedge clk); @(negedge clk);
      check("w64_held_high", b2.m_din, 8'h01);
      b2.m_ready_for_next_byte = 1'b0;
      @(negedge clk);
      for (int k = 1; k < 32; k++) begin
         check("w64_m_din", b2.m_din, 8'(k));
         check("w64_wend_early", b2.m_wend, 0);
         b2.m_ready_for_next_byte = 1'b1;
         @(negedge clk);
         b2.m_ready_for_next_byte = 1'b0;
         @(negedge clk);
      end
      check("w64_wend", b2.m_wend, 1);
      check("w64_idle", st2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
